// File: rtl/cbm2_slot_sequencer.sv
// Bus slot sequencer: free-running frame position counter with per-slot
// strobes, a refresh period counter and refresh-aligned pause handling.
module cbm2_slot_sequencer #(
   parameter int SLOTS    = 4,
   parameter int SLOT_LEN = 4,
   parameter int TAIL_LEN = 2,
   parameter int RFSH_DIV = 8,
   localparam int SW = $clog2(SLOTS + 1),
   localparam int UW = $clog2(SLOT_LEN),
   localparam int RW = (RFSH_DIV > 1) ? $clog2(RFSH_DIV) : 1,
   localparam int TW = (TAIL_LEN > 1) ? $clog2(TAIL_LEN) : 1
) (
   input  logic             clk_sys,
   input  logic             reset,
   input  logic             long_frame,
   input  logic             pause,
   input  logic [SLOTS-1:0] slot_en,
   input  logic [SLOTS-1:0] slot_fast,
   output logic [SW-1:0]    slot,
   output logic [UW-1:0]    sub,
   output logic             phase,
   output logic             slot_active,
   output logic             slot_first,
   output logic             slot_last,
   output logic             slot_after,
   output logic             frame_end,
   output logic             refresh,
   output logic [RW-1:0]    rfsh_index,
   output logic             pause_out
);

   logic [SW-1:0] slot_cnt, nxt_slot;
   logic [UW-1:0] sub_cnt, nxt_sub;
   logic [TW-1:0] tail_cnt, nxt_tail;
   logic          long_q, nxt_long;
   logic          sys_enable, nxt_en;
   logic          sel_en, sel_fast;
   logic [RW-1:0] nxt_rfsh;

   // Frame_end is registered, so it is predicted from the next position.
   function automatic logic is_end(input logic [SW-1:0] s, input logic [UW-1:0] u,
                                   input logic [TW-1:0] t, input logic lg);
      if (lg && (TAIL_LEN > 0))
         return (int'(s) == SLOTS) && (int'(t) == TAIL_LEN - 1);
      return (int'(s) == SLOTS - 1) && (int'(u) == SLOT_LEN - 1);
   endfunction

   always_comb begin
      nxt_slot = slot_cnt;
      nxt_sub  = sub_cnt;
      nxt_tail = tail_cnt;
      if (frame_end) begin
         nxt_slot = '0;
         nxt_sub  = '0;
         nxt_tail = '0;
      end else if (int'(slot_cnt) == SLOTS) begin
         nxt_tail = tail_cnt + 1'b1;
      end else if (int'(sub_cnt) == SLOT_LEN - 1) begin
         nxt_sub  = '0;
         nxt_slot = slot_cnt + 1'b1;
      end else begin
         nxt_sub = sub_cnt + 1'b1;
      end
      nxt_long = frame_end ? long_frame : long_q;
      nxt_en   = (frame_end && (rfsh_index == '0)) ? ~pause : sys_enable;
      nxt_rfsh = (int'(rfsh_index) == RFSH_DIV - 1) ? '0 : rfsh_index + 1'b1;
   end

   // Slot 0 is given up during the second frame of every refresh period.
   always_comb begin
      sel_en   = 1'b0;
      sel_fast = 1'b0;
      for (int i = 0; i < SLOTS; i++) begin
         if (int'(slot_cnt) == i) begin
            sel_en   = slot_en[i];
            sel_fast = slot_fast[i];
         end
      end
      slot_active = sys_enable && sel_en && (sel_fast || phase)
                    && !((slot_cnt == '0) && (int'(rfsh_index) == 1));
      slot_first  = slot_active && (sub_cnt == '0);
      slot_last   = slot_active && (int'(sub_cnt) == SLOT_LEN - 1);
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         slot_cnt   <= '0;
         sub_cnt    <= '0;
         tail_cnt   <= '0;
         long_q     <= 1'b0;
         sys_enable <= 1'b0;
         pause_out  <= 1'b1;
         slot       <= '0;
         sub        <= '0;
         frame_end  <= 1'b0;
         slot_after <= 1'b0;
         refresh    <= 1'b0;
         phase      <= 1'b0;
         rfsh_index <= '0;
      end else begin
         slot_cnt   <= nxt_slot;
         sub_cnt    <= nxt_sub;
         tail_cnt   <= nxt_tail;
         long_q     <= nxt_long;
         sys_enable <= nxt_en;
         pause_out  <= ~nxt_en;
         slot       <= nxt_en ? nxt_slot : '0;
         sub        <= nxt_en ? nxt_sub : '0;
         frame_end  <= is_end(nxt_slot, nxt_sub, nxt_tail, nxt_long);
         slot_after <= slot_last;
         refresh    <= frame_end && (rfsh_index == '0);
         if (frame_end) begin
            phase      <= ~phase;
            rfsh_index <= nxt_rfsh;
         end
      end
   end

endmodule

// File: tb/tb_cbm2_slot_sequencer.sv
// Scoreboard bench for cbm2_slot_sequencer: a flat-position frame model queues
// the expected outputs each cycle, a monitor compares them on the falling edge.
module tb_cbm2_slot_sequencer;

   localparam int SLOTS = 4, SLOT_LEN = 4, TAIL_LEN = 2, RFSH_DIV = 8;

   logic       clk_sys = 1'b0, reset = 1'b1, long_frame = 1'b0, pause = 1'b0;
   logic [3:0] slot_en = 4'hF, slot_fast = 4'hF;
   logic [2:0] slot;
   logic [1:0] sub;
   logic       phase, slot_active, slot_first, slot_last, slot_after;
   logic       frame_end, refresh, pause_out;
   logic [2:0] rfsh_index;

   cbm2_slot_sequencer #(.SLOTS(SLOTS), .SLOT_LEN(SLOT_LEN), .TAIL_LEN(TAIL_LEN),
                         .RFSH_DIV(RFSH_DIV)) dut (
      .clk_sys(clk_sys), .reset(reset), .long_frame(long_frame), .pause(pause),
      .slot_en(slot_en), .slot_fast(slot_fast), .slot(slot), .sub(sub),
      .phase(phase), .slot_active(slot_active), .slot_first(slot_first),
      .slot_last(slot_last), .slot_after(slot_after), .frame_end(frame_end),
      .refresh(refresh), .rfsh_index(rfsh_index), .pause_out(pause_out));

   always #5 clk_sys = ~clk_sys;

   typedef struct packed {
      logic [2:0] slot;
      logic [1:0] sub;
      logic       phase, active, first, last, after, fend, refresh;
      logic [2:0] ridx;
      logic       pause_out;
   } obs_t;

   obs_t exp_q[$];
   int checks = 0, failures = 0;

   int m_pos = 0, m_ridx = 0;
   bit m_long = 0, m_phase = 0, m_en = 0, m_refresh = 0, m_after = 0;

   function automatic int frame_len(bit lg);
      return SLOTS * SLOT_LEN + (lg ? TAIL_LEN : 0);
   endfunction

   function automatic bit model_active(int pos, bit en, bit ph, int ridx,
                                       logic [3:0] e, logic [3:0] f);
      int s;
      if (pos >= SLOTS * SLOT_LEN) return 1'b0;
      s = pos / SLOT_LEN;
      return en && e[s] && (f[s] || ph) && !(s == 0 && ridx == 1);
   endfunction

   // Reference model: advance on each edge, then queue this cycle's outputs.
   always @(posedge clk_sys) begin
      bit rst_edge, lg_in, pz_in, end_prev, last_prev, a;
      logic [3:0] e_in, f_in;
      int s, u;
      obs_t o;
      rst_edge  = reset;
      lg_in     = long_frame;
      pz_in     = pause;
      e_in      = slot_en;
      f_in      = slot_fast;
      end_prev  = (m_pos == frame_len(m_long) - 1);
      last_prev = model_active(m_pos, m_en, m_phase, m_ridx, e_in, f_in)
                  && (m_pos % SLOT_LEN == SLOT_LEN - 1);
      #2;
      if (rst_edge || reset) begin
         m_pos = 0; m_ridx = 0; m_long = 0; m_phase = 0;
         m_en = 0; m_refresh = 0; m_after = 0;
      end else begin
         m_after   = last_prev;
         m_refresh = end_prev && (m_ridx == 0);
         if (end_prev) begin
            if (m_ridx == 0) m_en = !pz_in;
            m_phase = !m_phase;
            m_ridx  = (m_ridx + 1) % RFSH_DIV;
            m_long  = lg_in;
            m_pos   = 0;
         end else begin
            m_pos++;
         end
      end
      s = (m_pos < SLOTS * SLOT_LEN) ? m_pos / SLOT_LEN : SLOTS;
      u = (m_pos < SLOTS * SLOT_LEN) ? m_pos % SLOT_LEN : 0;
      a = model_active(m_pos, m_en, m_phase, m_ridx, slot_en, slot_fast);
      o.slot      = m_en ? 3'(s) : 3'd0;
      o.sub       = m_en ? 2'(u) : 2'd0;
      o.phase     = m_phase;
      o.active    = a;
      o.first     = a && (u == 0);
      o.last      = a && (u == SLOT_LEN - 1);
      o.after     = m_after;
      o.fend      = (m_pos == frame_len(m_long) - 1);
      o.refresh   = m_refresh;
      o.ridx      = 3'(m_ridx);
      o.pause_out = !m_en;
      exp_q.push_back(o);
   end

   always @(negedge clk_sys) begin
      obs_t e, a;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         a = {slot, sub, phase, slot_active, slot_first, slot_last, slot_after,
              frame_end, refresh, rfsh_index, pause_out};
         checks++;
         if (a !== e) begin
            failures++;
            $display("[TB] FAIL scoreboard t=%0t actual=%h required=%h", $time, a, e);
         end
      end
   end

   task automatic check_output(input string name, input int actual, input int required);
      checks++;
      if (actual != required) begin
         failures++;
         $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, required);
      end
   endtask

   task automatic apply_stimulus(input bit lg, input bit pz, input logic [3:0] e,
                                 input logic [3:0] f);
      @(posedge clk_sys);
      #1;
      long_frame = lg;
      pause      = pz;
      slot_en    = e;
      slot_fast  = f;
   endtask

   task automatic wait_frame_ridx(input int r);
      bit ok = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk_sys);
         if (frame_end && (r < 0 || int'(rfsh_index) == r)) begin
            ok = 1;
            break;
         end
      end
      if (!ok) check_output("timeout_frame_end", 0, 1);
   endtask

   // Called with reset released just after an edge: the next negedge is cycle 1.
   task automatic measure_restart();
      int first_ref = 0, firsts = 0, slot21 = 0;
      bit po16 = 0, po17 = 0;
      for (int c = 1; c <= 24; c++) begin
         @(negedge clk_sys);
         if (refresh && first_ref == 0) first_ref = c;
         if (c == 16) po16 = pause_out;
         if (c == 17) po17 = pause_out;
         if (c == 21) slot21 = int'(slot);
         if (slot_first) firsts++;
      end
      check_output("first_refresh_cycle", first_ref, 17);
      check_output("pause_out_cycle16", int'(po16), 1);
      check_output("pause_out_cycle17", int'(po17), 0);
      check_output("slot_at_cycle21", slot21, 1);
      check_output("firsts_cycles_1_24", firsts, 1);
   endtask

   initial begin
      int len, tail, tail_act, s1_first, s1_phase0, after_err, fends;
      int s0_first, other_first, po_hi, po_lo, refs, nz_slot;
      bit prev_last;

      repeat (3) @(posedge clk_sys);
      @(negedge clk_sys);
      check_output("reset_pause_out", int'(pause_out), 1);
      check_output("reset_refresh", int'(refresh), 0);
      @(posedge clk_sys);
      #1 reset = 1'b0;
      measure_restart();

      // Long frames: the first frame after latching carries a 2-cycle tail.
      apply_stimulus(1, 0, 4'hF, 4'hF);
      wait_frame_ridx(-1);
      len = 0; tail = 0; tail_act = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk_sys);
         len++;
         if (slot == 3'd4) tail++;
         if (slot == 3'd4 && slot_active) tail_act++;
         if (frame_end) break;
      end
      check_output("long_frame_len", len, 18);
      check_output("tail_cycles", tail, 2);
      check_output("tail_active", tail_act, 0);

      // Slow slot 1: strobes only in phase=1 frames.
      apply_stimulus(0, 0, 4'hF, 4'b1101);
      wait_frame_ridx(-1);
      s1_first = 0; s1_phase0 = 0; after_err = 0; fends = 0; prev_last = 0;
      for (int i = 0; i < 200 && fends < 4; i++) begin
         @(negedge clk_sys);
         if (slot_first && slot == 3'd1) s1_first++;
         if (slot_active && slot == 3'd1 && !phase) s1_phase0++;
         if (slot_after != prev_last) after_err++;
         prev_last = slot_last;
         if (frame_end) fends++;
      end
      check_output("slot1_firsts_4_frames", s1_first, 2);
      check_output("slot1_active_phase0", s1_phase0, 0);
      check_output("slot_after_follows_last", after_err, 0);

      // rfsh_index==1 frame: slot 0 is withheld, slots 1-3 still run.
      apply_stimulus(0, 0, 4'hF, 4'hF);
      wait_frame_ridx(0);
      s0_first = 0; other_first = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk_sys);
         if (slot_first && slot == 3'd0) s0_first++;
         if (slot_first && slot != 3'd0) other_first++;
         if (frame_end) break;
      end
      check_output("rfsh1_slot0_firsts", s0_first, 0);
      check_output("rfsh1_other_firsts", other_first, 3);

      // Pause raised mid-period waits for the refresh boundary.
      wait_frame_ridx(2);
      apply_stimulus(0, 1, 4'hF, 4'hF);
      po_hi = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk_sys);
         if (pause_out) po_hi++;
         if (frame_end && rfsh_index == 3'd0) break;
      end
      check_output("pause_before_boundary", po_hi, 0);
      apply_stimulus(0, 0, 4'hF, 4'hF);
      fends = 0; po_lo = 0; refs = 0; nz_slot = 0; s0_first = 0;
      for (int i = 0; i < 400 && fends < 8; i++) begin
         if (i > 0) @(negedge clk_sys);
         else @(negedge clk_sys);
         if (!pause_out) po_lo++;
         if (refresh) refs++;
         if (slot != 3'd0) nz_slot++;
         if (slot_first || slot_last || slot_active) s0_first++;
         if (frame_end) fends++;
      end
      check_output("paused_pause_out_low", po_lo, 0);
      check_output("paused_refreshes", refs, 1);
      check_output("paused_slot_nonzero", nz_slot, 0);
      check_output("paused_strobes", s0_first, 0);
      po_hi = 0; other_first = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk_sys);
         if (pause_out) po_hi++;
         if (slot_first) other_first++;
         if (frame_end) break;
      end
      check_output("resume_pause_out", po_hi, 0);
      check_output("resume_firsts", other_first, 3);

      // Reset during cycle 9 of a frame aborts it on the spot.
      wait_frame_ridx(-1);
      repeat (9) @(posedge clk_sys);
      #1 reset = 1'b1;
      @(negedge clk_sys);
      check_output("midreset_slot", int'(slot), 0);
      check_output("midreset_pause_out", int'(pause_out), 1);
      check_output("midreset_rfsh_index", int'(rfsh_index), 0);
      refs = 0;
      repeat (3) begin
         @(negedge clk_sys);
         if (refresh || frame_end) refs++;
      end
      check_output("midreset_no_pulses", refs, 0);
      @(posedge clk_sys);
      #1 reset = 1'b0;
      measure_restart();

      repeat (4) @(negedge clk_sys);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/cbm2_slot_sequencer.md
CBM2_SLOT_SEQUENCER -- requirements
Module: cbm2_slot_sequencer

Interface
REQ-001 Parameter SLOTS, default 4: number of numbered bus slots per frame (EXT, CPU, COP, VID order).
REQ-002 Parameter SLOT_LEN, default 4: clk_sys cycles per slot; SHALL be >= 2.
REQ-003 Parameter TAIL_LEN, default 2: idle cycles appended to a long frame.
REQ-004 Parameter RFSH_DIV, default 8, power of two: frames per refresh period.
REQ-005 clk_sys  in  1  system clock, all logic on its rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 long_frame  in  1  1 = next frame includes the TAIL_LEN tail.
REQ-008 pause  in  1  request to halt slot activity.
REQ-009 slot_en  in  SLOTS  per-slot enable.
REQ-010 slot_fast  in  SLOTS  1 = slot active every frame; 0 = active only when phase=1.
REQ-011 slot  out  clog2(SLOTS+1)  current slot index; value SLOTS = tail.
REQ-012 sub  out  clog2(SLOT_LEN)  cycle index within slot; 0 in tail.
REQ-013 phase  out  1  toggles once per frame.
REQ-014 slot_active  out  1  current cycle belongs to an active slot.
REQ-015 slot_first / slot_last / slot_after  out  1 each  strobes: sub==0, sub==SLOT_LEN-1, and the cycle after slot_last, all of an active slot.
REQ-016 frame_end  out  1  high on the last cycle of each frame.
REQ-017 refresh  out  1  one-cycle refresh pulse.
REQ-018 rfsh_index  out  clog2(RFSH_DIV)  frame counter within the refresh period.
REQ-019 pause_out  out  1  high while slot activity is halted.

Function
REQ-020 Frame length SHALL be SLOTS*SLOT_LEN, plus TAIL_LEN if long_frame was high at the previous frame_end (16/18 cycles at defaults).
REQ-021 The position counter SHALL run freely every cycle, regardless of pause or enable state.
REQ-022 On each frame_end cycle the sequencer SHALL, at the next edge: toggle phase; increment rfsh_index modulo RFSH_DIV; latch long_frame.
REQ-023 On a frame_end cycle with rfsh_index==0, the sequencer SHALL also load internal sys_enable with ~pause and assert refresh for exactly the following cycle.
REQ-024 Pause therefore SHALL take effect only at a refresh boundary; pause changes at any other time SHALL have no effect until then.
REQ-025 pause_out SHALL equal ~sys_enable.
REQ-026 The active condition SHALL be: sys_enable & slot<SLOTS & slot_en[slot] & (slot_fast[slot] | phase) & ~(slot==0 & rfsh_index==1).
REQ-027 slot_active SHALL be high exactly when the active condition holds.
REQ-028 slot_first and slot_last SHALL be the active condition ANDed with sub==0 and sub==SLOT_LEN-1 respectively.
REQ-029 slot_after SHALL be slot_last delayed one cycle, and SHALL fire even if the next cycle is a frame start, is in the tail, or follows sys_enable falling.
REQ-030 While sys_enable=0: slot and sub SHALL read 0; slot_active, slot_first and slot_last SHALL be 0; phase, frame_end, refresh and rfsh_index SHALL continue to operate.
REQ-031 slot_en and slot_fast SHALL be sampled combinationally each cycle; a change mid-slot SHALL gate only the remaining strobes of that slot.
REQ-032 All outputs except the combinational strobes in REQ-026 to REQ-029 SHALL be registered.

Reset
REQ-033 On reset, the counter SHALL be set to frame position 0, and the following SHALL be 0: phase, rfsh_index, sys_enable, latched long_frame, refresh, slot_after.
REQ-034 After reset, pause_out SHALL be 1 until the first frame_end, at which ~pause is loaded (rfsh_index==0).
REQ-035 Reset asserted mid-frame SHALL abort the frame immediately, with no frame_end or refresh pulse generated.

Verification
REQ-036 Reset release, pause=0, long_frame=0, all slots enabled and fast -> pause_out falls after cycle 16; refresh high on cycle 17; slot sequence 0,1,2,3 with 4 cycles each.
REQ-037 long_frame=1 held -> first frame 16 cycles, subsequent frames 18 cycles; slot==4 and slot_active=0 during the 2 tail cycles; frame_end on cycle 18.
REQ-038 slot_fast[1]=0 -> slot 1 strobes appear only in frames with phase=1, alternating frames; slot_after follows each slot_last by exactly 1 cycle.
REQ-039 rfsh_index==1 frame -> slot 0 inactive (no slot_first for slot 0) while slots 1-3 remain active.
REQ-040 pause=1 raised when rfsh_index=3 -> no effect until the frame_end with rfsh_index=0; then pause_out=1 with slot=0 and no strobes, while refresh still pulses every 8 frames; pause=0 resumes at the next refresh boundary.
REQ-041 Reset asserted at cycle 9 of a frame -> outputs return to reset values within the same cycle; no refresh pulse; the sequence restarts per REQ-036.
